fetch_sequencer: RTL and testbench

- Controls the instruction-fetch path. Owns the PC and drives a request/response handshake to instruction memory.
- Presents one fetched instruction at a time, with its PC, to decode over a valid/ready handshake.
- Handles branch/jump redirects and squashes stale in-flight fetches.
- Replaces the free-running PC increment with a stall- and redirect-aware sequencer.

---
 rtl/fetch_sequencer.sv | 161 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues one memory request at a time and buffers one instruction for decode.
// Optional misaligned-redirect trap is enabled with the FETCH_MISALIGN_TRAP_EN macro.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] PC_STEP      = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        fetch_misalign,
  output logic [31:0] misalign_pc,
`endif
  output logic        busy
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [1:0] ST_TRAP = 2'd3;
`endif

  logic [1:0]  state_reg;
  logic [31:0] pc_reg;
  logic        squash_reg;
  logic        inst_valid_reg;
  logic [31:0] inst_out_reg;
  logic [31:0] inst_pc_reg;
  logic [31:0] redirect_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign_reg;
  logic [31:0] misalign_pc_reg;
  logic        redirect_misaligned;

  assign redirect_target     = redirect_pc;
  assign redirect_misaligned = |redirect_pc[1:0];
  assign fetch_misalign      = fetch_misalign_reg;
  assign misalign_pc         = misalign_pc_reg;
`else
  logic unused_low_bits;

  // Without the trap, targets are forced to word alignment.
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign unused_low_bits = ^redirect_pc[1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_REQ;
      pc_reg         <= RESET_VECTOR;
      squash_reg     <= 1'b0;
      inst_valid_reg <= 1'b0;
      inst_out_reg   <= 32'd0;
      inst_pc_reg    <= 32'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_misalign_reg <= 1'b0;
      misalign_pc_reg    <= 32'd0;
`endif
    end else if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_misaligned) begin
        fetch_misalign_reg <= 1'b1;
        misalign_pc_reg    <= redirect_pc;
        inst_valid_reg     <= 1'b0;
        state_reg          <= ST_TRAP;
        // Track whether a response is still owed so it is discarded after leaving TRAP.
        if (state_reg == ST_REQ) begin
          squash_reg <= imem_ready;
        end else if (state_reg == ST_WAIT) begin
          squash_reg <= !imem_rvalid;
        end else if (state_reg == ST_TRAP && imem_rvalid) begin
          squash_reg <= 1'b0;
        end
      end else begin
        fetch_misalign_reg <= 1'b0;
`endif
        pc_reg <= redirect_target;
        case (state_reg)
          ST_REQ: begin
            if (imem_ready) begin
              squash_reg <= 1'b1;
              state_reg  <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (imem_rvalid) begin
              squash_reg <= 1'b0;
              state_reg  <= ST_REQ;
            end else begin
              squash_reg <= 1'b1;
            end
          end
          ST_HOLD: begin
            inst_valid_reg <= 1'b0;
            state_reg      <= ST_REQ;
          end
          default: begin
            if (squash_reg && !imem_rvalid) begin
              state_reg <= ST_WAIT;
            end else begin
              squash_reg <= 1'b0;
              state_reg  <= ST_REQ;
            end
          end
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
      end
`endif
    end else begin
      case (state_reg)
        ST_REQ: begin
          if (imem_ready) state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (squash_reg) begin
              squash_reg <= 1'b0;
              state_reg  <= ST_REQ;
            end else begin
              inst_out_reg   <= imem_rdata;
              inst_pc_reg    <= pc_reg;
              inst_valid_reg <= 1'b1;
              pc_reg         <= pc_reg + PC_STEP;
              state_reg      <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (inst_ready) begin
            inst_valid_reg <= 1'b0;
            state_reg      <= ST_REQ;
          end
        end
        default: begin
          // Parked in TRAP: a late response for a squashed request retires the squash.
          if (imem_rvalid) squash_reg <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = (state_reg == ST_REQ);
  assign imem_addr  = pc_reg;
  assign busy       = (state_reg == ST_WAIT);
  assign inst_valid = inst_valid_reg;
  assign inst_out   = inst_out_reg;
  assign inst_pc    = inst_pc_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed vector table, hand-written corner sequences,
// and a randomized run checked against a delivered-instruction-stream model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        busy;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign;
  logic [31:0] misalign_pc;
  logic        w_fetch_misalign;
  logic [31:0] w_misalign_pc;
`endif

  // Second instance exercising PC wrap-around from the top of the address space.
  logic        w_req, w_valid, w_busy;
  logic [31:0] w_addr, w_out, w_pc;
  logic        w_ready = 1'b1;
  logic        w_rvalid = 1'b0;
  logic        w_iready = 1'b1;
  logic [31:0] w_addrs[$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc),
    .inst_ready(inst_ready),
`ifdef FETCH_MISALIGN_TRAP_EN
    .fetch_misalign(fetch_misalign), .misalign_pc(misalign_pc),
`endif
    .busy(busy)
  );

  fetch_sequencer #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst),
    .redirect_valid(1'b0), .redirect_pc(32'd0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(w_ready),
    .imem_rvalid(w_rvalid), .imem_rdata(32'h0000_0013),
    .inst_valid(w_valid), .inst_out(w_out), .inst_pc(w_pc),
    .inst_ready(w_iready),
`ifdef FETCH_MISALIGN_TRAP_EN
    .fetch_misalign(w_fetch_misalign), .misalign_pc(w_misalign_pc),
`endif
    .busy(w_busy)
  );

  // Memory for the wrap instance: answers one cycle after acceptance; logs distinct fetch addresses.
  always @(negedge clk) begin
    w_rvalid = w_busy;
    if (w_req === 1'b1 && w_addrs.size() < 4) begin
      if (w_addrs.size() == 0 || w_addrs[w_addrs.size()-1] != w_addr) w_addrs.push_back(w_addr);
    end
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rdy, rv;
    logic [31:0] rdata;
    logic        irdy, rdv;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_busy, e_iv;
    logic [31:0] e_ipc, e_iout;
  } vec_t;

  vec_t tbl[27];

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rdata,
                              input logic irdy, input logic rdv, input logic [31:0] rpc,
                              input logic e_req, input logic [31:0] e_addr, input logic e_busy,
                              input logic e_iv, input logic [31:0] e_ipc, input logic [31:0] e_iout);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.irdy = irdy; v.rdv = rdv; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_busy = e_busy; v.e_iv = e_iv;
    v.e_ipc = e_ipc; v.e_iout = e_iout;
    return v;
  endfunction

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rdata,
                       input logic irdy, input logic rdv, input logic [31:0] rpc);
    imem_ready = rdy; imem_rvalid = rv; imem_rdata = rdata;
    inst_ready = irdy; redirect_valid = rdv; redirect_pc = rpc;
  endtask

  task automatic chk_state(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_busy, input logic e_iv, input logic [31:0] e_ipc,
                           input logic [31:0] e_iout);
    chk({tag, ".imem_req"}, 32'(imem_req), 32'(e_req));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".inst_valid"}, 32'(inst_valid), 32'(e_iv));
    if (e_req) chk({tag, ".imem_addr"}, imem_addr, e_addr);
    if (e_iv) begin
      chk({tag, ".inst_pc"}, inst_pc, e_ipc);
      chk({tag, ".inst_out"}, inst_out, e_iout);
    end
  endtask

  initial begin
    logic        outstanding;
    logic [31:0] out_addr;
    int          cnt, idle, delivered;
    logic [31:0] exp_pc, rpc;
    logic        rdv, irdy, rdy;

    // Rows: inputs applied this cycle | outputs expected before applying them.
    tbl[0]  = mk(1,0,0,             0,0,0,       1,32'h0,  0,0,0,0);
    tbl[1]  = mk(0,1,mem_word(0),   1,0,0,       0,0,      1,0,0,0);
    tbl[2]  = mk(1,0,0,             1,0,0,       0,0,      0,1,32'h0,mem_word(0));
    tbl[3]  = mk(1,0,0,             0,0,0,       1,32'h4,  0,0,0,0);
    tbl[4]  = mk(0,1,mem_word(4),   0,0,0,       0,0,      1,0,0,0);
    tbl[5]  = mk(1,1,32'h1111_1111, 0,0,0,       0,0,      0,1,32'h4,mem_word(4));
    tbl[6]  = mk(0,0,0,             0,0,0,       0,0,      0,1,32'h4,mem_word(4));
    tbl[7]  = mk(1,1,32'h2222_2222, 0,0,0,       0,0,      0,1,32'h4,mem_word(4));
    tbl[8]  = mk(0,0,0,             0,0,0,       0,0,      0,1,32'h4,mem_word(4));
    tbl[9]  = mk(1,1,32'h3333_3333, 0,0,0,       0,0,      0,1,32'h4,mem_word(4));
    tbl[10] = mk(0,0,0,             1,0,0,       0,0,      0,1,32'h4,mem_word(4));
    tbl[11] = mk(1,0,0,             0,0,0,       1,32'h8,  0,0,0,0);
    tbl[12] = mk(0,0,0,             0,1,32'h100, 0,0,      1,0,0,0);
    tbl[13] = mk(0,0,0,             0,0,0,       0,0,      1,0,0,0);
    tbl[14] = mk(0,1,32'hDEAD_BEEF, 1,0,0,       0,0,      1,0,0,0);
    tbl[15] = mk(1,0,0,             1,0,0,       1,32'h100,0,0,0,0);
    tbl[16] = mk(0,1,mem_word(32'h100),1,0,0,    0,0,      1,0,0,0);
    tbl[17] = mk(0,0,0,             1,0,0,       0,0,      0,1,32'h100,mem_word(32'h100));
    tbl[18] = mk(1,0,0,             0,1,32'h200, 1,32'h104,0,0,0,0);
    tbl[19] = mk(0,1,32'hBAD0_BAD0, 1,0,0,       0,0,      1,0,0,0);
    tbl[20] = mk(1,0,0,             0,0,0,       1,32'h200,0,0,0,0);
    tbl[21] = mk(0,1,mem_word(32'h200),0,0,0,    0,0,      1,0,0,0);
    tbl[22] = mk(0,0,0,             1,1,32'h300, 0,0,      0,1,32'h200,mem_word(32'h200));
    tbl[23] = mk(0,0,0,             0,1,32'h400, 1,32'h300,0,0,0,0);
    tbl[24] = mk(1,0,0,             0,0,0,       1,32'h400,0,0,0,0);
    tbl[25] = mk(0,1,32'h5555_5555, 0,1,32'h500, 0,0,      1,0,0,0);
    tbl[26] = mk(0,0,0,             0,0,0,       1,32'h500,0,0,0,0);

    rst = 1'b1;
    drive(0,0,0,0,0,0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 27; i++) begin
      chk_state($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_busy,
                tbl[i].e_iv, tbl[i].e_ipc, tbl[i].e_iout);
      drive(tbl[i].rdy, tbl[i].rv, tbl[i].rdata, tbl[i].irdy, tbl[i].rdv, tbl[i].rpc);
      $display("vec %0d req=%0b addr=%h busy=%0b iv=%0b ipc=%h", i, imem_req, imem_addr, busy, inst_valid, inst_pc);
      @(negedge clk);
    end

    // Reset while a request is outstanding, then a late response.
    drive(1,0,0,0,0,0);
    @(negedge clk);
    chk_state("rstwait.pre", 0, 0, 1, 0, 0, 0);
    rst = 1'b1;
    drive(0,0,0,0,0,0);
    @(negedge clk);
    rst = 1'b0;
    chk_state("rstwait.after", 1, 32'h0, 0, 0, 0, 0);
    drive(0,1,32'h7777_7777,1,0,0);
    @(negedge clk);
    chk_state("rstwait.late_rvalid", 1, 32'h0, 0, 0, 0, 0);
    $display("seq rst_during_wait addr=%h iv=%0b", imem_addr, inst_valid);

`ifdef FETCH_MISALIGN_TRAP_EN
    drive(0,0,0,0,1,32'h102);
    @(negedge clk);
    chk("trap.fetch_misalign", 32'(fetch_misalign), 32'd1);
    chk("trap.misalign_pc", misalign_pc, 32'h102);
    chk_state("trap.enter", 0, 0, 0, 0, 0, 0);
    drive(1,0,0,1,0,0);
    @(negedge clk);
    chk("trap.parked", 32'(fetch_misalign), 32'd1);
    chk_state("trap.hold", 0, 0, 0, 0, 0, 0);
    drive(0,0,0,0,1,32'h104);
    @(negedge clk);
    chk("trap.cleared", 32'(fetch_misalign), 32'd0);
    chk_state("trap.leave", 1, 32'h104, 0, 0, 0, 0);
    drive(1,0,0,0,0,0);
    @(negedge clk);
    drive(0,1,mem_word(32'h104),0,0,0);
    @(negedge clk);
    chk_state("trap.deliver", 0, 0, 0, 1, 32'h104, mem_word(32'h104));
    $display("seq misalign_trap ipc=%h", inst_pc);
`else
    drive(0,0,0,0,1,32'h103);
    @(negedge clk);
    chk_state("lowbits.redirect", 1, 32'h100, 0, 0, 0, 0);
    drive(1,0,0,0,0,0);
    @(negedge clk);
    drive(0,1,mem_word(32'h100),0,0,0);
    @(negedge clk);
    chk_state("lowbits.deliver", 0, 0, 0, 1, 32'h100, mem_word(32'h100));
    $display("seq lowbits_ignored ipc=%h", inst_pc);
`endif

    chk("wrap.log_size", 32'(w_addrs.size() >= 2), 32'd1);
    if (w_addrs.size() >= 2) begin
      chk("wrap.first_addr", w_addrs[0], 32'hFFFF_FFFC);
      chk("wrap.second_addr", w_addrs[1], 32'h0000_0000);
      $display("seq wrap first=%h second=%h", w_addrs[0], w_addrs[1]);
    end

    // Randomized run: the delivered stream must be consecutive words starting at the last redirect.
    rst = 1'b1;
    drive(0,0,0,0,0,0);
    @(negedge clk);
    rst = 1'b0;
    outstanding = 1'b0; out_addr = 32'd0; cnt = 0; idle = 0; delivered = 0;
    exp_pc = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      if (imem_req) chk("rand.single_outstanding", 32'(outstanding), 32'd0);
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (outstanding) begin
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(out_addr);
          outstanding = 1'b0;
        end else begin
          cnt--;
        end
      end else if ($urandom_range(0, 4) == 0) begin
        imem_rvalid = 1'b1;
      end
      rdy  = ($urandom_range(0, 1) == 1);
      irdy = ($urandom_range(0, 9) < 6);
      rdv  = ($urandom_range(0, 9) == 0);
      rpc  = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      rpc[1:0] = 2'b00;
`endif
      imem_ready = rdy; inst_ready = irdy; redirect_valid = rdv; redirect_pc = rpc;
      if (imem_req && rdy) begin
        outstanding = 1'b1;
        out_addr    = imem_addr;
        cnt         = $urandom_range(0, 2);
      end
      if (rdv) begin
        exp_pc = rpc & 32'hFFFF_FFFC;
        idle   = 0;
      end else if (inst_valid && irdy) begin
        chk("rand.inst_pc", inst_pc, exp_pc);
        chk("rand.inst_out", inst_out, mem_word(exp_pc));
        $display("rand deliver pc=%h inst=%h", inst_pc, inst_out);
        exp_pc = exp_pc + 32'd4;
        delivered++;
        idle = 0;
      end else begin
        idle++;
      end
      if (idle == 40) chk("rand.liveness_idle", 32'(idle), 32'd0);
      @(negedge clk);
    end
    chk("rand.deliveries_min", 32'(delivered >= 100), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
